// File: rtl/bch_gf16_pkg.sv
// bch_gf16_pkg: GF(2^4) types, constants and arithmetic helpers for the BCH(15,7) decoder
package bch_gf16_pkg;

    localparam int GF_M = 4;
    localparam logic [4:0] GF_POLY = 5'b10011;
    localparam int T = 2;

    typedef logic [GF_M-1:0] gf16_t;

    function automatic gf16_t gf_mul(gf16_t a, gf16_t b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < GF_M; i++)
            if (b[i]) p ^= 7'(a) << i;
        for (int i = 6; i >= GF_M; i--)
            if (p[i]) p ^= 7'(GF_POLY) << (i - GF_M);
        return p[GF_M-1:0];
    endfunction

    function automatic gf16_t gf_sq(gf16_t a);
        return gf_mul(a, a);
    endfunction

    function automatic gf16_t gf_inv(gf16_t a);
        case (a)
            4'h1: return 4'h1;
            4'h2: return 4'h9;
            4'h3: return 4'he;
            4'h4: return 4'hd;
            4'h5: return 4'hb;
            4'h6: return 4'h7;
            4'h7: return 4'h6;
            4'h8: return 4'hf;
            4'h9: return 4'h2;
            4'ha: return 4'hc;
            4'hb: return 4'h5;
            4'hc: return 4'ha;
            4'hd: return 4'h4;
            4'he: return 4'h3;
            4'hf: return 4'h8;
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/gf16_mul.sv
// gf16_mul: combinational 4x4 GF(2^4) multiplier modulo x^4+x+1
module gf16_mul
    import bch_gf16_pkg::*;
(
    input  gf16_t a,
    input  gf16_t b,
    output gf16_t p
);

    assign p = gf_mul(a, b);

endmodule

// File: rtl/bch_bm_block_p.sv
// bch_bm_block_p: 3-stage closed-form t=2 key-equation solver; BCH_BM_FAIL_FLAG_EN adds a fail output
module bch_bm_block_p
    import bch_gf16_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  gf16_t S1,
    input  gf16_t S2,
    input  gf16_t S3,
    output gf16_t lambda1,
    output gf16_t lambda2
`ifdef BCH_BM_FAIL_FLAG_EN
    ,
    output logic  fail
`endif
);

    gf16_t s1_q, s3_q, sq, cube, s1_r, s3_r, cube_r, inv_r, prod;

`ifdef BCH_BM_FAIL_FLAG_EN
    gf16_t s2_q;
    logic  fail_r;
`else
    logic  unused_s2;
    assign unused_s2 = ^S2;
`endif

    gf16_mul u_sq   (.a(s1_q), .b(s1_q), .p(sq));
    gf16_mul u_cube (.a(sq), .b(s1_q), .p(cube));
    // inv(0)=0 makes the product vanish, so S1==0 yields lambda2=0 for both no-error and uncorrectable cases
    gf16_mul u_prod (.a(s3_r ^ cube_r), .b(inv_r), .p(prod));

    // stage 0: register the incoming syndromes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s3_q <= '0;
`ifdef BCH_BM_FAIL_FLAG_EN
            s2_q <= '0;
`endif
        end else begin
            s1_q <= S1;
            s3_q <= S3;
`ifdef BCH_BM_FAIL_FLAG_EN
            s2_q <= S2;
`endif
        end
    end

    // stage 1: register S1^3, inv(S1), S3 and the raw S1 for lambda1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r   <= '0;
            s3_r   <= '0;
            cube_r <= '0;
            inv_r  <= '0;
`ifdef BCH_BM_FAIL_FLAG_EN
            fail_r <= 1'b0;
`endif
        end else begin
            s1_r   <= s1_q;
            s3_r   <= s3_q;
            cube_r <= cube;
            inv_r  <= gf_inv(s1_q);
`ifdef BCH_BM_FAIL_FLAG_EN
            fail_r <= (s1_q == '0 && s3_q != '0) || (s2_q != sq);
`endif
        end
    end

    // stage 2: register the normalized locator coefficients
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lambda1 <= '0;
            lambda2 <= '0;
`ifdef BCH_BM_FAIL_FLAG_EN
            fail    <= 1'b0;
`endif
        end else begin
            lambda1 <= s1_r;
            lambda2 <= prod;
`ifdef BCH_BM_FAIL_FLAG_EN
            fail    <= fail_r;
`endif
        end
    end

endmodule

// File: tb/tb_bch_bm_block_p.sv
// tb_bch_bm_block_p: randomized self-checking bench against a log/antilog GF(16) reference model
module tb_bch_bm_block_p;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] S1 = '0, S2 = '0, S3 = '0;
    logic [3:0] lambda1, lambda2;
    logic       fail_o;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_t [15];
    int         log_t [16];

    typedef struct {
        logic [3:0] l1;
        logic [3:0] l2;
        logic       f;
    } exp_s;

    exp_s q[$];

    always #5 clk = ~clk;

`ifdef BCH_BM_FAIL_FLAG_EN
    bch_bm_block_p dut (.clk(clk), .rst(rst), .S1(S1), .S2(S2), .S3(S3),
                        .lambda1(lambda1), .lambda2(lambda2), .fail(fail_o));
`else
    bch_bm_block_p dut (.clk(clk), .rst(rst), .S1(S1), .S2(S2), .S3(S3),
                        .lambda1(lambda1), .lambda2(lambda2));
    assign fail_o = 1'b0;
`endif

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [3:0] pw(input logic [3:0] a, input int k);
        return (a == 0) ? 4'h0 : 4'(exp_t[(k * log_t[a]) % 15]);
    endfunction

    function automatic exp_s model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        exp_s e;
        logic [3:0] d;
        d = c ^ pw(a, 3);
        e.l1 = a;
        e.l2 = (a == 0 || d == 0) ? 4'h0 : 4'(exp_t[(log_t[d] - log_t[a] + 15) % 15]);
        e.f  = (a == 0 && c != 0) || (b != pw(a, 2));
        return e;
    endfunction

    task automatic check_front();
        exp_s e;
        e = q.pop_front();
        chk("lambda1", lambda1, e.l1);
        chk("lambda2", lambda2, e.l2);
`ifdef BCH_BM_FAIL_FLAG_EN
        chk("fail", {3'b0, fail_o}, {3'b0, e.f});
`endif
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        @(negedge clk);
        if (q.size() == 3) check_front();
        S1 = a;
        S2 = b;
        S3 = c;
        q.push_back(model(a, b, c));
    endtask

    task automatic flush();
        repeat (3) begin
            @(negedge clk);
            if (q.size() > 0) check_front();
        end
    endtask

    task automatic apply_rand();
        logic [3:0] a, b, c;
        a = 4'($urandom_range(0, 15));
        c = ($urandom_range(0, 5) == 0) ? pw(a, 3) : 4'($urandom_range(0, 15));
        b = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : pw(a, 2);
        apply(a, b, c);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_l1"}, lambda1, 4'h0);
        chk({tag, "_l2"}, lambda2, 4'h0);
        chk({tag, "_fail"}, {3'b0, fail_o}, 4'h0);
    endtask

    initial begin
        int v;
        v = 1;
        for (int i = 0; i < 15; i++) begin
            exp_t[i] = v;
            log_t[v] = i;
            v = v << 1;
            if (v & 16) v ^= 19;
        end
        log_t[0] = 0;
        repeat (4) begin
            @(negedge clk);
            S1 = 4'($urandom_range(0, 15));
            S2 = 4'($urandom_range(0, 15));
            S3 = 4'($urandom_range(0, 15));
            #1 check_zero("reset");
        end
        @(negedge clk);
        rst = 1'b1;
        apply(4'h3, 4'h5, 4'h6);
        apply(4'h3, 4'h5, 4'h9);
        apply(4'h2, 4'h4, 4'h8);
        apply(4'h0, 4'h0, 4'h0);
        apply(4'h0, 4'h0, 4'h6);
        apply(4'h1, 4'h1, 4'h1);
        apply(4'h5, 4'h7, 4'h3);
        for (int i = 0; i < 60; i++) apply_rand();
        flush();
        repeat (5) apply_rand();
        #2 rst = 1'b0;
        #1 check_zero("midrst");
        q.delete();
        @(negedge clk);
        check_zero("midrst_hold");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) apply_rand();
        flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
